// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: FSM state encoding, idle line level
// and the helper that maps a state onto the serial line level.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic IDLE_LEVEL = 1'b1;

  // Line level to present while the FSM sits in `state`.
  function automatic logic line_level(input tx_state_t state,
                                      input logic      data_bit,
                                      input logic      parity_bit);
    logic level;
    case (state)
      START:   level = ~IDLE_LEVEL;
      DATA:    level = data_bit;
      PARITY:  level = parity_bit;
      default: level = IDLE_LEVEL;
    endcase
    return level;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// FIFO-side handshake and status bundle of the UART transmitter.
// master: the transmitter; slave: the FIFO / MCU status side.
interface uart_tx_ctrl_if #(
  parameter int DATA_BITS = 8
) ();

  logic                 emptyTx;
  logic [DATA_BITS-1:0] tx_data;
  logic                 trans_deq;
  logic                 serial_out;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    input  emptyTx,
    input  tx_data,
    output trans_deq,
    output serial_out,
    output tx_busy,
    output tx_done
  );

  modport slave (
    output emptyTx,
    output tx_data,
    input  trans_deq,
    input  serial_out,
    input  tx_busy,
    input  tx_done
  );

endinterface

// File: rtl/tx_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, held at 0 otherwise;
// bit_tick marks the last clock of each serial bit.
module tx_baud_counter #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic bit_tick
);

  localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_tick = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!enable || bit_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: pops bytes from a first-word-fall-through FIFO and
// serializes them as start / LSB-first data / optional even parity / stop frames.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8,
  parameter bit PARITY_EN    = 1'b0
) (
  input logic            clk,
  input logic            reset,
  uart_tx_ctrl_if.master bus
);

  localparam int               IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 parity_q, parity_d;
  logic                 serial_q, serial_d;
  logic                 done_q, done_d;
  logic                 baud_en;
  logic                 bit_tick;
  logic                 last_bit;

  assign baud_en  = state_q inside {START, DATA, PARITY, STOP};
  assign last_bit = (bit_idx_q == LAST_IDX);

  tx_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .enable   (baud_en),
    .bit_tick (bit_tick)
  );

  // ---------------------------------------------------------------- FSM state
  // NOTE: sequential blocks use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ----------------------------------------------------------- FSM next state
  // NOTE: the default assignment at the top keeps this block free of latches.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!bus.emptyTx) state_d = LOAD;
      LOAD:    state_d = START;
      START:   if (bit_tick) state_d = DATA;
      DATA:    if (bit_tick && last_bit) state_d = PARITY_EN ? PARITY : STOP;
      PARITY:  if (bit_tick) state_d = STOP;
      STOP:    if (bit_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------- datapath
  always_comb begin
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      LOAD: begin
        shift_d   = bus.tx_data;
        parity_d  = ^bus.tx_data;
        bit_idx_d = '0;
      end
      DATA: begin
        if (bit_tick) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = last_bit ? '0 : bit_idx_q + IDX_W'(1);
        end
      end
      default: ;
    endcase
  end

  // NOTE: the shift register is plain flops, not a memory array, so it is
  // cleared on reset together with the rest of the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_idx_q <= '0;
    end else begin
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  // -------------------------------------------------------------- FSM outputs
  // The line flop is fed from the next state, so the registered level lines up
  // with the state it belongs to (start bit low in the cycle right after LOAD).
  always_comb begin
    bus.trans_deq = (state_q == LOAD);
    bus.tx_busy   = (state_q != IDLE);
    serial_d      = line_level(state_d, shift_d[0], parity_d);
    done_d        = (state_q == STOP) && bit_tick;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      serial_q <= IDLE_LEVEL;
      done_q   <= 1'b0;
    end else begin
      serial_q <= serial_d;
      done_q   <= done_d;
    end
  end

  assign bus.serial_out = serial_q;
  assign bus.tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a no-parity and an even-parity instance,
// each fed from a queue-based FIFO model and checked every cycle by a frame model.
module tb_uart_tx_ctrl;

  localparam int CPB = 10;
  localparam int DB  = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.DATA_BITS(DB)) bus0 ();
  uart_tx_ctrl_if #(.DATA_BITS(DB)) bus1 ();

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_EN(1'b0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_EN(1'b1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  bit         chk_en  = 1'b0;
  bit         tog0    = 1'b0;
  bit         deq_seen [2];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // which: 0 trans_deq, 1 tx_done, 2 tx_busy, 3 serial_out
  function automatic logic pick(input int k, input int which);
    logic s;
    case (which)
      0:       s = (k == 0) ? bus0.trans_deq : bus1.trans_deq;
      1:       s = (k == 0) ? bus0.tx_done   : bus1.tx_done;
      2:       s = (k == 0) ? bus0.tx_busy   : bus1.tx_busy;
      default: s = (k == 0) ? bus0.serial_out : bus1.serial_out;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------- FIFO models
  initial begin
    bus0.emptyTx = 1'b1;
    bus0.tx_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (deq_seen[0]) begin
        deq_seen[0] = 1'b0;
        if (q0.size() > 0) void'(q0.pop_front());
      end
      if (tog0) begin
        bus0.emptyTx = cyc[0];
        bus0.tx_data = 8'($urandom);
      end else begin
        bus0.emptyTx = (q0.size() == 0);
        bus0.tx_data = (q0.size() > 0) ? q0[0] : 8'h00;
      end
    end
  end

  initial begin
    bus1.emptyTx = 1'b1;
    bus1.tx_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (deq_seen[1]) begin
        deq_seen[1] = 1'b0;
        if (q1.size() > 0) void'(q1.pop_front());
      end
      bus1.emptyTx = (q1.size() == 0);
      bus1.tx_data = (q1.size() > 0) ? q1[0] : 8'h00;
    end
  end

  // ------------------------------------------------- frame reference model
  // Bit idx of a frame: 0 start, 1..DB data LSB first, optional parity, stop.
  function automatic logic exp_line(input logic [7:0] b, input bit pen, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DB) return b[idx-1];
    if (pen && idx == DB + 1) return ^b;
    return 1'b1;
  endfunction

  bit         m_in   [2];
  bit         m_done [2];
  int         m_load [2];
  logic [7:0] m_byte [2];

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        logic [3:0] act;
        logic [3:0] exp_v;
        logic       em;
        logic [7:0] d;
        int         nb;
        if (k == 0) begin
          act = {bus0.trans_deq, bus0.tx_busy, bus0.tx_done, bus0.serial_out};
          em  = bus0.emptyTx;
          d   = bus0.tx_data;
        end else begin
          act = {bus1.trans_deq, bus1.tx_busy, bus1.tx_done, bus1.serial_out};
          em  = bus1.emptyTx;
          d   = bus1.tx_data;
        end
        nb = (k == 1) ? DB + 3 : DB + 2;
        if (m_in[k] && cyc == m_load[k]) m_byte[k] = d;
        exp_v[3] = m_in[k] && (cyc == m_load[k]);
        exp_v[2] = m_in[k];
        exp_v[1] = m_done[k];
        exp_v[0] = (!m_in[k] || cyc == m_load[k]) ? 1'b1 :
                   exp_line(m_byte[k], k == 1, (cyc - m_load[k] - 1) / CPB);
        if (k == 0) check("dut0 {deq,busy,done,line}", 32'(act), 32'(exp_v));
        else        check("dut1 {deq,busy,done,line}", 32'(act), 32'(exp_v));
        deq_seen[k] = act[3];
        m_done[k] = 1'b0;
        if (reset) begin
          m_in[k] = 1'b0;
        end else if (m_in[k]) begin
          if (cyc - m_load[k] == nb * CPB) begin
            m_in[k]   = 1'b0;
            m_done[k] = 1'b1;
          end
        end else if (!em) begin
          m_in[k]   = 1'b1;
          m_load[k] = cyc + 1;
        end
      end
    end
  end

  // ------------------------------------------------------------ helpers
  task automatic wait_sig(input int k, input int which, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pick(k, which)) begin
        at = cyc;
        break;
      end
    end
    n_tests++;
    if (at < 0) begin
      n_fail++;
      $display("FAIL wait dut%0d sig%0d: got none expected event within %0d cycles", k, which, budget);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && !bus0.tx_busy && !bus1.tx_busy) begin
        idle = 1'b1;
        break;
      end
    end
    @(negedge clk);
    check("drain to idle", 32'(idle), 32'd1);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         pen;
    logic       exp_par;
    int         exp_done;
  } vec_t;

  vec_t tbl [7];

  // ---------------------------------------------------------- main test
  initial begin
    int t1, t2, tl, td, extra;

    tbl[0] = '{8'hA5, 1'b0, 1'b0, 101};
    tbl[1] = '{8'h3C, 1'b0, 1'b0, 101};
    tbl[2] = '{8'h01, 1'b0, 1'b0, 101};
    tbl[3] = '{8'h07, 1'b1, 1'b1, 111};
    tbl[4] = '{8'hA5, 1'b1, 1'b0, 111};
    tbl[5] = '{8'h80, 1'b1, 1'b1, 111};
    tbl[6] = '{8'hFE, 1'b1, 1'b1, 111};

    // Reset held three cycles with the FIFO non-empty.
    reset = 1'b1;
    q0.push_back(8'h5A);
    q1.push_back(8'h5A);
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset outputs dut0", {28'd0, bus0.trans_deq, bus0.tx_busy, bus0.tx_done, bus0.serial_out}, 32'h1);
      check("reset outputs dut1", {28'd0, bus1.trans_deq, bus1.tx_busy, bus1.tx_done, bus1.serial_out}, 32'h1);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(negedge clk);
    check("idle cycle after reset deq", 32'(bus0.trans_deq), 32'd0);
    @(negedge clk);
    check("load after reset deq dut0", 32'(bus0.trans_deq), 32'd1);
    check("load after reset deq dut1", 32'(bus1.trans_deq), 32'd1);
    drain(400);

    // Table-driven single frames, sampled mid-bit.
    for (int i = 0; i < 7; i++) begin
      int   k, nb;
      logic eb;
      k  = tbl[i].pen ? 1 : 0;
      nb = tbl[i].pen ? DB + 3 : DB + 2;
      if (k == 0) q0.push_back(tbl[i].data);
      else        q1.push_back(tbl[i].data);
      wait_sig(k, 0, 50, tl);
      for (int b = 0; b < nb; b++) begin
        if (b == 0)                             eb = 1'b0;
        else if (b <= DB)                       eb = tbl[i].data[b-1];
        else if (tbl[i].pen && b == DB + 1)     eb = tbl[i].exp_par;
        else                                    eb = 1'b1;
        wait_cyc(tl + 1 + b * CPB + CPB / 2);
        check($sformatf("vec%0d line bit%0d", i, b), 32'(pick(k, 3)), 32'(eb));
      end
      wait_sig(k, 1, 150, td);
      check($sformatf("vec%0d done delay", i), td - tl, tbl[i].exp_done);
    end
    drain(300);

    // Back-to-back frames, no parity: 0x00 then 0xFF.
    q0.push_back(8'h00);
    q0.push_back(8'hFF);
    wait_sig(0, 0, 50, t1);
    wait_cyc(t1 + 100);
    check("b2b busy in stop", 32'(bus0.tx_busy), 32'd1);
    wait_cyc(t1 + 101);
    check("b2b busy gap", 32'(bus0.tx_busy), 32'd0);
    check("b2b done pulse", 32'(bus0.tx_done), 32'd1);
    wait_sig(0, 0, 150, t2);
    check("b2b load spacing", t2 - t1, 102);
    drain(300);

    // Back-to-back frames with parity.
    q1.push_back(8'h07);
    q1.push_back(8'hA5);
    wait_sig(1, 0, 50, t1);
    wait_sig(1, 0, 200, t2);
    check("parity load spacing", t2 - t1, 112);
    drain(300);

    // Reset during data bit 3 of 0x3C; the following byte must go out intact.
    q0.push_back(8'h3C);
    wait_sig(0, 0, 50, tl);
    q0.push_back(8'hC3);
    wait_cyc(tl + 1 + 4 * CPB + CPB / 2);
    check("line at data bit 3", 32'(bus0.serial_out), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid-frame reset line", 32'(bus0.serial_out), 32'd1);
    check("mid-frame reset busy", 32'(bus0.tx_busy), 32'd0);
    check("mid-frame reset done", 32'(bus0.tx_done), 32'd0);
    wait_sig(0, 0, 20, t2);
    wait_sig(0, 1, 150, td);
    check("frame after reset done delay", td - t2, 101);
    drain(300);

    // emptyTx toggling with junk data mid-frame must not pop or disturb the frame.
    q0.push_back(8'h5B);
    wait_sig(0, 0, 50, tl);
    wait_cyc(tl + 5);
    tog0  = 1'b1;
    extra = 0;
    while (cyc < tl + 80) begin
      @(negedge clk);
      if (bus0.trans_deq) extra++;
    end
    tog0 = 1'b0;
    check("toggle extra deq", extra, 0);
    wait_sig(0, 1, 150, td);
    check("toggle done delay", td - tl, 101);
    drain(300);

    // Randomized traffic on both instances, checked by the frame model.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 0) q0.push_back(8'($urandom));
      else                           q1.push_back(8'($urandom));
      repeat ($urandom_range(0, 150)) @(negedge clk);
    end
    drain(4000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
